shift_pload_sout_n: RTL and testbench
=====================================

SHIFT_PLOAD_SOUT_N -- requirements
Module: shift_pload_sout_n

Interface
REQ-001 Parameter WIDTH, default 8: shift register width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 = bit WIDTH-1 leaves first; 0 = bit 0 leaves first.
REQ-003 Parameter FILL, default 0: bit value shifted into the vacated end.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 abort  input  1  synchronous cancel of the word in flight.
REQ-007 load  input  1  request to load data; accepted only when ready=1.
REQ-008 data  input  WIDTH  parallel word to serialise.
REQ-009 shift_en  input  1  advance one bit this cycle (clock enable for shifting).
REQ-010 ready  output  1  load will be accepted this cycle.
REQ-011 sout  output  1  current serial output bit.
REQ-012 busy  output  1  a word is in flight (state SHIFT).
REQ-013 done  output  1  one-cycle pulse after the last bit of a word is shifted out.
REQ-014 overrun  output  1  sticky: load was asserted while ready=0.
REQ-015 bits_left  output  CNT_W  bits of the current word not yet shifted out; CNT_W = clog2(WIDTH+1).
REQ-016 dout  output  WIDTH  debug view of the shift register.

Function
REQ-017 Two states: IDLE (busy=0) and SHIFT (busy=1).
REQ-018 ready = (state==IDLE) OR (state==SHIFT AND bits_left==1 AND shift_en==1); combinational.
REQ-019 Accepted load (load AND ready): next cycle dout=data, bits_left=WIDTH, state=SHIFT.
REQ-020 sout = dout[WIDTH-1] when MSB_FIRST=1, else dout[0]; valid in the cycle after load.
REQ-021 SHIFT AND shift_en AND no accepted load: dout shifts one place toward the sout end, FILL enters the opposite end, bits_left decrements by 1.
REQ-022 SHIFT AND shift_en=0: dout, bits_left, and state hold.
REQ-023 Last bit (bits_left==1 AND shift_en) without load: next cycle state=IDLE, bits_left=0, done=1 for exactly one cycle.
REQ-024 Last bit with simultaneous load (back-to-back): new word loaded per REQ-019, state stays SHIFT, no idle gap; done still pulses for the finished word.
REQ-025 IDLE: shift_en has no effect; dout holds its last value; bits_left=0.
REQ-026 IDLE with load AND shift_en: load wins; no shift that cycle.
REQ-027 load while ready=0: the request is ignored, dout and bits_left are unaffected, and overrun sets to 1 next cycle.
REQ-028 overrun clears only on rst, or on an accepted load when load is the only event that cycle.
REQ-029 abort: next cycle state=IDLE, dout=0, bits_left=0, done=0; overrides load and shift_en in the same cycle; overrun unchanged.
REQ-030 Priority within one cycle: rst > abort > accepted load > shift.
REQ-031 bits_left never wraps: it never goes below 0 and never exceeds WIDTH.

Reset
REQ-032 rst=1 at a rising edge: state=IDLE, dout=0, bits_left=0, done=0, overrun=0; therefore sout=0, busy=0, ready=1.
REQ-033 rst mid-word discards the word without a done pulse; the first edge after release behaves as IDLE.

Structure
REQ-034 A shared package holds the state encoding (IDLE=0, SHIFT=1) and the CNT_W width function.
REQ-035 No sub-module: the register, counter and FSM are in one module; all outputs are driven from registers except ready.

Verification
REQ-036 WIDTH=8, MSB_FIRST=1: load 0xA5, shift_en held 1 -> sout 1,0,1,0,0,1,0,1; done pulses on the cycle after the 8th shift; bits_left 8..1 then 0.
REQ-037 WIDTH=8, MSB_FIRST=0, FILL=1: load 0x01 -> sout 1 then 0 x7; dout after 8 shifts = 0xFF.
REQ-038 Back-to-back: load 0x3C then 0xC3 on the last-bit cycle -> 16 contiguous bits 00111100 11000011; busy never drops; done pulses once per word.
REQ-039 load 0x55 mid-word -> overrun=1, word unchanged; the next accepted load clears overrun.
REQ-040 shift_en gapped (1,0,0,1,...) -> bits_left and sout hold during the gaps; abort at bits_left=5 -> IDLE, dout=0, no done pulse.
REQ-041 WIDTH=16 and WIDTH=2 instances: rst asserted mid-word -> all outputs at reset values next cycle; full word round-trips correctly afterwards.

Source files
------------

// File: rtl/shift_pload_sout_n_pkg.sv
// Shared definitions for the parallel-load / serial-out shifter.
package shift_pload_sout_n_pkg;

   // Controller states; busy is simply state == SHIFT.
   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   // Width of a counter that must hold every value 0..width inclusive.
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/shift_pload_sout_n.sv
// Parallel-load, serial-out shift register with back-to-back load support,
// abort, a sticky overrun flag and a one-cycle done pulse per word.
module shift_pload_sout_n
   import shift_pload_sout_n_pkg::*;
#(
   parameter int  WIDTH     = 8,
   parameter bit  MSB_FIRST = 1'b1,
   parameter bit  FILL      = 1'b0,
   localparam int CNT_W     = cnt_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             abort,
   input  logic             load,
   input  logic [WIDTH-1:0] data,
   input  logic             shift_en,
   output logic             ready,
   output logic             sout,
   output logic             busy,
   output logic             done,
   output logic             overrun,
   output logic [CNT_W-1:0] bits_left,
   output logic [WIDTH-1:0] dout
);

   state_t           state, state_nxt;
   logic [WIDTH-1:0] dout_nxt;
   logic [WIDTH-1:0] dout_shifted;
   logic [CNT_W-1:0] bits_left_nxt;
   logic             done_nxt;
   logic             overrun_nxt;
   logic             last_bit;
   logic             accept;

   // The final bit leaves this cycle, so a new word may be taken in its place.
   assign last_bit = (state == SHIFT) && (bits_left == CNT_W'(1)) && shift_en;
   assign ready    = (state == IDLE) || last_bit;
   assign accept   = load && ready;

   assign busy = (state == SHIFT);
   assign sout = MSB_FIRST ? dout[WIDTH-1] : dout[0];

   // One-place move toward the sout end, FILL entering the far end.
   always_comb begin
      dout_shifted = dout;
      if (MSB_FIRST) dout_shifted = {dout[WIDTH-2:0], FILL};
      else           dout_shifted = {FILL, dout[WIDTH-1:1]};
   end

   // Next-state logic; abort beats load, load beats shift.
   always_comb begin
      state_nxt     = state;
      dout_nxt      = dout;
      bits_left_nxt = bits_left;
      done_nxt      = 1'b0;
      overrun_nxt   = overrun;
      if (abort) begin
         // Word discarded, no done pulse, overrun left as it was.
         state_nxt     = IDLE;
         dout_nxt      = '0;
         bits_left_nxt = '0;
      end else begin
         if (load && !ready) overrun_nxt = 1'b1;
         if (accept) begin
            state_nxt     = SHIFT;
            dout_nxt      = data;
            bits_left_nxt = CNT_W'(WIDTH);
            // A load on the last-bit cycle still completes the old word.
            done_nxt      = last_bit;
            // Only a load with nothing else happening clears the flag.
            if (!shift_en) overrun_nxt = 1'b0;
         end else if ((state == SHIFT) && shift_en) begin
            dout_nxt = dout_shifted;
            if (bits_left != '0) bits_left_nxt = bits_left - CNT_W'(1);
            if (bits_left == CNT_W'(1)) begin
               state_nxt = IDLE;
               done_nxt  = 1'b1;
            end
         end
      end
   end

   // State, shift register, counter and flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         dout      <= '0;
         bits_left <= '0;
         done      <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         state     <= state_nxt;
         dout      <= dout_nxt;
         bits_left <= bits_left_nxt;
         done      <= done_nxt;
         overrun   <= overrun_nxt;
      end
   end

endmodule

// File: tb/tb_shift_pload_sout_n.sv
// Directed bench: four instances (8-bit MSB-first, 8-bit LSB-first with
// FILL=1, 16-bit, 2-bit) share control inputs and have separate data.
module tb_shift_pload_sout_n;

   logic clk = 1'b0;
   logic rst, abort, load, shift_en;
   logic [7:0]  d8, d8l;
   logic [15:0] d16;
   logic [1:0]  d2;

   logic ready8, sout8, busy8, done8, ovr8;
   logic [3:0] bits8;
   logic [7:0] dout8;
   logic ready8l, sout8l, busy8l, done8l, ovr8l;
   logic [3:0] bits8l;
   logic [7:0] dout8l;
   logic ready16, sout16, busy16, done16, ovr16;
   logic [4:0]  bits16;
   logic [15:0] dout16;
   logic ready2, sout2, busy2, done2, ovr2;
   logic [1:0] bits2;
   logic [1:0] dout2;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   shift_pload_sout_n #(.WIDTH(8), .MSB_FIRST(1'b1), .FILL(1'b0)) u8 (
      .clk(clk), .rst(rst), .abort(abort), .load(load), .data(d8), .shift_en(shift_en),
      .ready(ready8), .sout(sout8), .busy(busy8), .done(done8), .overrun(ovr8),
      .bits_left(bits8), .dout(dout8));

   shift_pload_sout_n #(.WIDTH(8), .MSB_FIRST(1'b0), .FILL(1'b1)) u8l (
      .clk(clk), .rst(rst), .abort(abort), .load(load), .data(d8l), .shift_en(shift_en),
      .ready(ready8l), .sout(sout8l), .busy(busy8l), .done(done8l), .overrun(ovr8l),
      .bits_left(bits8l), .dout(dout8l));

   shift_pload_sout_n #(.WIDTH(16)) u16 (
      .clk(clk), .rst(rst), .abort(abort), .load(load), .data(d16), .shift_en(shift_en),
      .ready(ready16), .sout(sout16), .busy(busy16), .done(done16), .overrun(ovr16),
      .bits_left(bits16), .dout(dout16));

   shift_pload_sout_n #(.WIDTH(2)) u2 (
      .clk(clk), .rst(rst), .abort(abort), .load(load), .data(d2), .shift_en(shift_en),
      .ready(ready2), .sout(sout2), .busy(busy2), .done(done2), .overrun(ovr2),
      .bits_left(bits2), .dout(dout2));

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; load = 1'b1; shift_en = 1'b1; abort = 1'b0;
      tick();
      rst = 1'b0; load = 1'b0; shift_en = 1'b0;
      checks++; if (dout8 !== 8'h00) begin errors++; $display("FAIL reset_dout got %0h exp 0", dout8); end
      checks++; if (bits8 !== 4'd0) begin errors++; $display("FAIL reset_bits got %0d exp 0", bits8); end
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy8); end
      checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", ready8); end
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done8); end
      checks++; if (ovr8 !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b exp 0", ovr8); end
      checks++; if (sout8 !== 1'b0) begin errors++; $display("FAIL reset_sout got %b exp 0", sout8); end
   endtask

   task automatic test_msb_first();
      logic [7:0] exp;
      exp = 8'hA5;
      d8 = 8'hA5; d8l = 8'hA5; load = 1'b1; shift_en = 1'b0;
      tick();
      load = 1'b0; shift_en = 1'b1;
      checks++; if (dout8 !== 8'hA5) begin errors++; $display("FAIL msb_load_dout got %0h exp a5", dout8); end
      checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL msb_busy got %b exp 1", busy8); end
      for (int i = 0; i < 8; i++) begin
         checks++; if (sout8 !== exp[7-i]) begin errors++; $display("FAIL msb_sout[%0d] got %b exp %b", i, sout8, exp[7-i]); end
         checks++; if (bits8 !== 4'(8 - i)) begin errors++; $display("FAIL msb_bits[%0d] got %0d exp %0d", i, bits8, 8 - i); end
         checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL msb_done_early[%0d] got %b exp 0", i, done8); end
         tick();
      end
      checks++; if (done8 !== 1'b1) begin errors++; $display("FAIL msb_done got %b exp 1", done8); end
      checks++; if (bits8 !== 4'd0) begin errors++; $display("FAIL msb_bits_end got %0d exp 0", bits8); end
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL msb_busy_end got %b exp 0", busy8); end
      tick();
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL msb_done_once got %b exp 0", done8); end
      checks++; if (dout8 !== 8'h00) begin errors++; $display("FAIL msb_idle_dout got %0h exp 0", dout8); end
      shift_en = 1'b0;
   endtask

   task automatic test_lsb_fill();
      d8l = 8'h01; load = 1'b1; shift_en = 1'b0;
      tick();
      load = 1'b0; shift_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         checks++; if (sout8l !== (i == 0)) begin errors++; $display("FAIL lsb_sout[%0d] got %b exp %b", i, sout8l, (i == 0)); end
         tick();
      end
      checks++; if (dout8l !== 8'hFF) begin errors++; $display("FAIL lsb_fill_dout got %0h exp ff", dout8l); end
      checks++; if (done8l !== 1'b1) begin errors++; $display("FAIL lsb_done got %b exp 1", done8l); end
      shift_en = 1'b0;
      tick();
   endtask

   task automatic test_back_to_back();
      logic [15:0] exp;
      exp = 16'h3CC3;
      d8 = 8'h3C; load = 1'b1; shift_en = 1'b0;
      tick();
      d8 = 8'hC3; shift_en = 1'b1;
      for (int k = 0; k < 16; k++) begin
         load = (k == 7);
         if (k == 7) begin
            checks++; if (ready8 !== 1'b1) begin errors++; $display("FAIL b2b_ready got %b exp 1", ready8); end
         end
         if (k == 8) begin
            checks++; if (bits8 !== 4'd8) begin errors++; $display("FAIL b2b_reload_bits got %0d exp 8", bits8); end
         end
         checks++; if (sout8 !== exp[15-k]) begin errors++; $display("FAIL b2b_sout[%0d] got %b exp %b", k, sout8, exp[15-k]); end
         checks++; if (busy8 !== 1'b1) begin errors++; $display("FAIL b2b_busy[%0d] got %b exp 1", k, busy8); end
         checks++; if (done8 !== (k == 8)) begin errors++; $display("FAIL b2b_done[%0d] got %b exp %b", k, done8, (k == 8)); end
         tick();
      end
      load = 1'b0;
      checks++; if (done8 !== 1'b1) begin errors++; $display("FAIL b2b_done_end got %b exp 1", done8); end
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL b2b_busy_end got %b exp 0", busy8); end
      checks++; if (ovr8 !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b exp 0", ovr8); end
      shift_en = 1'b0;
      tick();
   endtask

   task automatic test_overrun();
      d8 = 8'h96; load = 1'b1; shift_en = 1'b0;
      tick();
      load = 1'b0; shift_en = 1'b1;
      tick(); tick();
      shift_en = 1'b0;
      checks++; if (ready8 !== 1'b0) begin errors++; $display("FAIL ovr_ready got %b exp 0", ready8); end
      d8 = 8'h55; load = 1'b1;
      tick();
      load = 1'b0;
      checks++; if (ovr8 !== 1'b1) begin errors++; $display("FAIL ovr_set got %b exp 1", ovr8); end
      checks++; if (dout8 !== 8'h58) begin errors++; $display("FAIL ovr_dout got %0h exp 58", dout8); end
      checks++; if (bits8 !== 4'd6) begin errors++; $display("FAIL ovr_bits got %0d exp 6", bits8); end
      shift_en = 1'b1;
      repeat (6) tick();
      shift_en = 1'b0;
      checks++; if (done8 !== 1'b1) begin errors++; $display("FAIL ovr_word_done got %b exp 1", done8); end
      checks++; if (ovr8 !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", ovr8); end
      d8 = 8'h12; load = 1'b1;
      tick();
      load = 1'b0;
      checks++; if (ovr8 !== 1'b0) begin errors++; $display("FAIL ovr_clear got %b exp 0", ovr8); end
      checks++; if (dout8 !== 8'h12) begin errors++; $display("FAIL ovr_newload got %0h exp 12", dout8); end
      checks++; if (bits8 !== 4'd8) begin errors++; $display("FAIL ovr_newbits got %0d exp 8", bits8); end
   endtask

   // Continues from the word 0x12 left loaded by test_overrun.
   task automatic test_gap_abort();
      int en_pat[6]   = '{1, 0, 0, 1, 0, 1};
      int exp_bits[6] = '{7, 7, 7, 6, 6, 5};
      int exp_dout[6] = '{'h24, 'h24, 'h24, 'h48, 'h48, 'h90};
      for (int i = 0; i < 6; i++) begin
         shift_en = en_pat[i][0];
         tick();
         checks++; if (bits8 !== 4'(exp_bits[i])) begin errors++; $display("FAIL gap_bits[%0d] got %0d exp %0d", i, bits8, exp_bits[i]); end
         checks++; if (dout8 !== 8'(exp_dout[i])) begin errors++; $display("FAIL gap_dout[%0d] got %0h exp %0h", i, dout8, exp_dout[i]); end
      end
      checks++; if (sout8 !== 1'b1) begin errors++; $display("FAIL gap_sout got %b exp 1", sout8); end
      abort = 1'b1; load = 1'b1; shift_en = 1'b1; d8 = 8'hFF;
      tick();
      abort = 1'b0; load = 1'b0; shift_en = 1'b0;
      checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b exp 0", busy8); end
      checks++; if (dout8 !== 8'h00) begin errors++; $display("FAIL abort_dout got %0h exp 0", dout8); end
      checks++; if (bits8 !== 4'd0) begin errors++; $display("FAIL abort_bits got %0d exp 0", bits8); end
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL abort_done got %b exp 0", done8); end
      checks++; if (ovr8 !== 1'b0) begin errors++; $display("FAIL abort_overrun got %b exp 0", ovr8); end
      tick();
      checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL abort_done_late got %b exp 0", done8); end
   endtask

   task automatic test_reset_mid();
      logic [15:0] rx16;
      logic [1:0]  rx2;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      d16 = 16'hBEEF; d2 = 2'b10; load = 1'b1; shift_en = 1'b0;
      tick();
      load = 1'b0; shift_en = 1'b1;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++; if (dout16 !== 16'h0) begin errors++; $display("FAIL rmid16_dout got %0h exp 0", dout16); end
      checks++; if (bits16 !== 5'd0) begin errors++; $display("FAIL rmid16_bits got %0d exp 0", bits16); end
      checks++; if (busy16 !== 1'b0) begin errors++; $display("FAIL rmid16_busy got %b exp 0", busy16); end
      checks++; if (ready16 !== 1'b1) begin errors++; $display("FAIL rmid16_ready got %b exp 1", ready16); end
      checks++; if (sout16 !== 1'b0) begin errors++; $display("FAIL rmid16_sout got %b exp 0", sout16); end
      checks++; if (dout2 !== 2'b00) begin errors++; $display("FAIL rmid2_dout got %0h exp 0", dout2); end
      checks++; if (bits2 !== 2'd0) begin errors++; $display("FAIL rmid2_bits got %0d exp 0", bits2); end
      checks++; if (busy2 !== 1'b0) begin errors++; $display("FAIL rmid2_busy got %b exp 0", busy2); end
      tick();
      checks++; if (done2 !== 1'b0) begin errors++; $display("FAIL rmid2_done got %b exp 0", done2); end
      checks++; if (busy16 !== 1'b0 || dout16 !== 16'h0) begin errors++; $display("FAIL rmid16_idle got busy %b dout %0h exp 0 0", busy16, dout16); end
      d16 = 16'h1234; d2 = 2'b01; load = 1'b1; shift_en = 1'b0;
      tick();
      load = 1'b0; shift_en = 1'b1;
      rx16 = '0; rx2 = '0;
      for (int k = 0; k < 16; k++) begin
         rx16 = {rx16[14:0], sout16};
         if (k < 2) rx2 = {rx2[0], sout2};
         checks++; if (done16 !== 1'b0) begin errors++; $display("FAIL rt16_done_early[%0d] got %b exp 0", k, done16); end
         tick();
      end
      shift_en = 1'b0;
      checks++; if (rx16 !== 16'h1234) begin errors++; $display("FAIL rt16_word got %0h exp 1234", rx16); end
      checks++; if (done16 !== 1'b1) begin errors++; $display("FAIL rt16_done got %b exp 1", done16); end
      checks++; if (rx2 !== 2'b01) begin errors++; $display("FAIL rt2_word got %0h exp 1", rx2); end
   endtask

   initial begin
      rst = 1'b1; abort = 1'b0; load = 1'b0; shift_en = 1'b0;
      d8 = '0; d8l = '0; d16 = '0; d2 = '0;
      test_reset();
      test_msb_first();
      test_lsb_fill();
      test_back_to_back();
      test_overrun();
      test_gap_abort();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
